// File: rtl/iomem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iomem_ctrl
// Brief    : CPU iomem bridge to four page-decoded peripheral slots with
//            access timeout, error logging and an internal status register.
// Revision : 1.0
// ============================================================================
module iomem_ctrl #(
  parameter logic [7:0]  SLOT0_PAGE = 8'h03,
  parameter logic [7:0]  SLOT1_PAGE = 8'h04,
  parameter logic [7:0]  SLOT2_PAGE = 8'h05,
  parameter logic [7:0]  SLOT3_PAGE = 8'h07,
  parameter logic [7:0]  STAT_PAGE  = 8'h0F,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         iomem_valid,
  output logic         iomem_ready,
  input  logic [3:0]   iomem_wstrb,
  input  logic [31:0]  iomem_addr,
  input  logic [31:0]  iomem_wdata,
  output logic [31:0]  iomem_rdata,
  output logic [3:0]   p_sel,
  output logic [3:0]   p_wstrb,
  output logic [31:0]  p_addr,
  output logic [31:0]  p_wdata,
  input  logic [3:0]   p_ready,
  input  logic [127:0] p_rdata,
  output logic         bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The counter reaches this value on the last permitted ACCESS cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  p_sel_q, p_sel_d;
  logic [3:0]  p_wstrb_q, p_wstrb_d;
  logic [31:0] p_addr_q, p_addr_d;
  logic [31:0] p_wdata_q, p_wdata_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [23:0] err_addr_q, err_addr_d;
  logic        bus_err_q, bus_err_d;

  logic        page_hit;
  logic        stat_hit;
  logic [1:0]  page_slot;
  logic        slot_ready;
  logic [31:0] slot_rdata;
  logic        err_rec;
  logic [23:0] err_rec_addr;
  logic        stat_clr;

  always_comb begin
    page_hit  = 1'b1;
    stat_hit  = 1'b0;
    page_slot = 2'd0;
    if (iomem_addr[31:24] == SLOT0_PAGE) begin
      page_slot = 2'd0;
    end else if (iomem_addr[31:24] == SLOT1_PAGE) begin
      page_slot = 2'd1;
    end else if (iomem_addr[31:24] == SLOT2_PAGE) begin
      page_slot = 2'd2;
    end else if (iomem_addr[31:24] == SLOT3_PAGE) begin
      page_slot = 2'd3;
    end else begin
      page_hit = 1'b0;
      stat_hit = (iomem_addr[31:24] == STAT_PAGE);
    end
  end

  // Only the selected slot's handshake and data are ever looked at.
  always_comb begin
    slot_ready = p_ready[slot_q];
    slot_rdata = p_rdata[{slot_q, 5'b00000} +: 32];
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    cnt_d        = cnt_q;
    ready_d      = 1'b0;
    rdata_d      = rdata_q;
    p_sel_d      = p_sel_q;
    p_wstrb_d    = p_wstrb_q;
    p_addr_d     = p_addr_q;
    p_wdata_d    = p_wdata_q;
    err_rec      = 1'b0;
    err_rec_addr = p_addr_q[23:0];
    stat_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (iomem_valid) begin
          p_addr_d  = iomem_addr;
          p_wdata_d = iomem_wdata;
          p_wstrb_d = iomem_wstrb;
          if (page_hit) begin
            p_sel_d = 4'b0001 << page_slot;
            slot_d  = page_slot;
            cnt_d   = 8'd0;
            state_d = ACCESS;
          end else if (stat_hit) begin
            rdata_d  = {err_addr_q, err_cnt_q};
            stat_clr = |iomem_wstrb;
            ready_d  = 1'b1;
            state_d  = DONE;
          end else begin
            rdata_d      = 32'hFFFF_FFFF;
            err_rec      = 1'b1;
            err_rec_addr = iomem_addr[23:0];
            ready_d      = 1'b1;
            state_d      = DONE;
          end
        end
      end

      // A completion in the final counted cycle beats the timeout.
      ACCESS: begin
        if (slot_ready) begin
          rdata_d = slot_rdata;
          p_sel_d = 4'b0000;
          ready_d = 1'b1;
          state_d = DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rdata_d = 32'hFFFF_FFFF;
          p_sel_d = 4'b0000;
          err_rec = 1'b1;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        p_sel_d = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    bus_err_d  = bus_err_q;
    if (stat_clr) begin
      err_cnt_d  = 8'd0;
      err_addr_d = 24'd0;
      bus_err_d  = 1'b0;
    end else if (err_rec) begin
      err_cnt_d  = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
      err_addr_d = err_rec_addr;
      bus_err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      slot_q     <= 2'd0;
      cnt_q      <= 8'd0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      p_sel_q    <= 4'd0;
      p_wstrb_q  <= 4'd0;
      p_addr_q   <= 32'd0;
      p_wdata_q  <= 32'd0;
      err_cnt_q  <= 8'd0;
      err_addr_q <= 24'd0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      p_sel_q    <= p_sel_d;
      p_wstrb_q  <= p_wstrb_d;
      p_addr_q   <= p_addr_d;
      p_wdata_q  <= p_wdata_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign p_sel       = p_sel_q;
  assign p_wstrb     = p_wstrb_q;
  assign p_addr      = p_addr_q;
  assign p_wdata     = p_wdata_q;
  assign bus_err     = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_iomem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iomem_ctrl
// Brief    : Directed self-checking bench for iomem_ctrl (TIMEOUT = 8).
// Revision : 1.0
// ============================================================================
module tb_iomem_ctrl;

  logic         clk = 1'b0;
  logic         resetn;
  logic         iomem_valid;
  logic         iomem_ready;
  logic [3:0]   iomem_wstrb;
  logic [31:0]  iomem_addr;
  logic [31:0]  iomem_wdata;
  logic [31:0]  iomem_rdata;
  logic [3:0]   p_sel;
  logic [3:0]   p_wstrb;
  logic [31:0]  p_addr;
  logic [31:0]  p_wdata;
  logic [3:0]   p_ready;
  logic [127:0] p_rdata;
  logic         bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iomem_ctrl #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .p_sel       (p_sel),
    .p_wstrb     (p_wstrb),
    .p_addr      (p_addr),
    .p_wdata     (p_wdata),
    .p_ready     (p_ready),
    .p_rdata     (p_rdata),
    .bus_err     (bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wdata = d;
    iomem_wstrb = s;
  endtask

  // Full CPU transaction with a bounded wait for iomem_ready.
  task automatic cpu_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd  = 32'hDEAD_DEAD;
    drive(a, d, s);
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (iomem_ready === 1'b1) begin
        got = 1'b1;
        rd  = iomem_rdata;
      end
    end
    iomem_valid = 1'b0;
    step();
    if (!got) begin
      total++; bad++;
      $display("FAIL cpu_op_timeout addr=%h: no iomem_ready within 40 cycles", a);
    end
  endtask

  task automatic test_reset();
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    p_ready     = 4'h0;
    p_rdata     = '0;
    step(); step();
    total++; if (iomem_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", iomem_ready); end
    total++; if (p_sel !== 4'h0) begin bad++; $display("FAIL rst_psel got=%b exp=0000", p_sel); end
    total++; if (iomem_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", iomem_rdata); end
    total++; if (p_addr !== 32'h0) begin bad++; $display("FAIL rst_paddr got=%h exp=0", p_addr); end
    total++; if (p_wdata !== 32'h0) begin bad++; $display("FAIL rst_pwdata got=%h exp=0", p_wdata); end
    total++; if (p_wstrb !== 4'h0) begin bad++; $display("FAIL rst_pwstrb got=%h exp=0", p_wstrb); end
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL rst_buserr got=%b exp=0", bus_err); end
    resetn = 1'b1;
  endtask

  task automatic test_zero_wait();
    p_ready = 4'b0001;
    p_rdata = {32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'h0000_00A5};
    drive(32'h0300_0004, 32'h0, 4'h0);
    step();
    total++; if (p_sel !== 4'b0001) begin bad++; $display("FAIL zw_sel got=%b exp=0001", p_sel); end
    total++; if (iomem_ready !== 1'b0) begin bad++; $display("FAIL zw_early_ready got=%b exp=0", iomem_ready); end
    total++; if (p_addr !== 32'h0300_0004) begin bad++; $display("FAIL zw_paddr got=%h exp=03000004", p_addr); end
    step();
    total++; if (iomem_ready !== 1'b1) begin bad++; $display("FAIL zw_ready got=%b exp=1", iomem_ready); end
    total++; if (iomem_rdata !== 32'h0000_00A5) begin bad++; $display("FAIL zw_rdata got=%h exp=000000a5", iomem_rdata); end
    total++; if (p_sel !== 4'b0000) begin bad++; $display("FAIL zw_sel_clr got=%b exp=0000", p_sel); end
    iomem_valid = 1'b0;
    p_ready     = 4'b0000;
    step();
    total++; if (iomem_ready !== 1'b0) begin bad++; $display("FAIL zw_ready_pulse got=%b exp=0", iomem_ready); end
    total++; if (iomem_rdata !== 32'h0000_00A5) begin bad++; $display("FAIL zw_rdata_hold got=%h exp=000000a5", iomem_rdata); end
  endtask

  task automatic test_wait_write();
    int sel_cycles;
    int pulses;
    sel_cycles = 0;
    pulses     = 0;
    // Unselected slots claim ready with junk data; they must be ignored.
    p_ready = 4'b0111;
    p_rdata = {32'hCAFE_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
    drive(32'h0700_0000, 32'h1234_5678, 4'hF);
    step();
    if (p_sel === 4'b1000) sel_cycles++;
    total++; if (p_wdata !== 32'h1234_5678) begin bad++; $display("FAIL ww_pwdata got=%h exp=12345678", p_wdata); end
    total++; if (p_wstrb !== 4'hF) begin bad++; $display("FAIL ww_pwstrb got=%h exp=f", p_wstrb); end
    for (int i = 0; i < 5; i++) begin
      step();
      if (p_sel === 4'b1000) sel_cycles++;
      if (iomem_ready === 1'b1) pulses++;
    end
    p_ready = 4'b1111;
    step();
    if (iomem_ready === 1'b1) pulses++;
    total++; if (iomem_rdata !== 32'hCAFE_0003) begin bad++; $display("FAIL ww_rdata got=%h exp=cafe0003", iomem_rdata); end
    total++; if (p_sel !== 4'b0000) begin bad++; $display("FAIL ww_sel_clr got=%b exp=0000", p_sel); end
    iomem_valid = 1'b0;
    p_ready     = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      if (iomem_ready === 1'b1) pulses++;
    end
    total++; if (sel_cycles != 6) begin bad++; $display("FAIL ww_sel_cycles got=%0d exp=6", sel_cycles); end
    total++; if (pulses != 1) begin bad++; $display("FAIL ww_ready_pulses got=%0d exp=1", pulses); end
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL ww_buserr got=%b exp=0", bus_err); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    int early;
    early   = 0;
    p_ready = 4'b0000;
    drive(32'h0400_0000, 32'h0, 4'h0);
    step();
    total++; if (p_sel !== 4'b0010) begin bad++; $display("FAIL to_sel got=%b exp=0010", p_sel); end
    // Dropping valid mid-access must not abort the transaction.
    iomem_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (iomem_ready !== 1'b0 || p_sel !== 4'b0010) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL to_early got=%0d bad cycles exp=0", early); end
    step();
    total++; if (iomem_ready !== 1'b1) begin bad++; $display("FAIL to_ready got=%b exp=1", iomem_ready); end
    total++; if (iomem_rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL to_rdata got=%h exp=ffffffff", iomem_rdata); end
    total++; if (p_sel !== 4'b0000) begin bad++; $display("FAIL to_sel_clr got=%b exp=0000", p_sel); end
    step();
    total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL to_buserr got=%b exp=1", bus_err); end
    cpu_op(32'h0F00_0000, 32'h0, 4'h0, rd);
    total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL to_status got=%h exp=00000001", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    cpu_op(32'h0F00_0000, 32'h0, 4'h1, rd);
    drive(32'h0900_0010, 32'h0, 4'h0);
    step();
    total++; if (iomem_ready !== 1'b1) begin bad++; $display("FAIL um_ready got=%b exp=1", iomem_ready); end
    total++; if (iomem_rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL um_rdata got=%h exp=ffffffff", iomem_rdata); end
    total++; if (p_sel !== 4'b0000) begin bad++; $display("FAIL um_sel got=%b exp=0000", p_sel); end
    total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL um_buserr got=%b exp=1", bus_err); end
    iomem_valid = 1'b0;
    step();
    cpu_op(32'h0F00_0000, 32'h0, 4'h0, rd);
    total++; if (rd !== 32'h0000_1001) begin bad++; $display("FAIL um_status got=%h exp=00001001", rd); end
    cpu_op(32'h0F00_0000, 32'h0, 4'h1, rd);
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL um_clr_buserr got=%b exp=0", bus_err); end
    cpu_op(32'h0F00_0000, 32'h0, 4'h0, rd);
    total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL um_clr_status got=%h exp=00000000", rd); end
  endtask

  task automatic test_saturate();
    logic [31:0] rd;
    for (int i = 0; i < 254; i++) cpu_op(32'h0800_0000 + 32'(i), 32'h0, 4'h0, rd);
    cpu_op(32'h0F00_0000, 32'h0, 4'h0, rd);
    total++; if (rd !== 32'h0000_FDFE) begin bad++; $display("FAIL sat_254 got=%h exp=0000fdfe", rd); end
    for (int i = 254; i < 300; i++) cpu_op(32'h0800_0000 + 32'(i), 32'h0, 4'h0, rd);
    cpu_op(32'h0F00_0000, 32'h0, 4'h0, rd);
    total++; if (rd !== 32'h0001_2BFF) begin bad++; $display("FAIL sat_300 got=%h exp=00012bff", rd); end
  endtask

  task automatic test_ready_vs_timeout();
    logic [31:0] rd;
    int early;
    early = 0;
    cpu_op(32'h0F00_0000, 32'h0, 4'hF, rd);
    p_ready = 4'b0000;
    p_rdata = {32'h0, 32'h5A5A_0002, 32'h0, 32'h0};
    drive(32'h0500_0000, 32'h0, 4'h0);
    step();
    total++; if (p_sel !== 4'b0100) begin bad++; $display("FAIL rt_sel got=%b exp=0100", p_sel); end
    iomem_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (iomem_ready !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL rt_early got=%0d exp=0", early); end
    p_ready = 4'b0100;
    step();
    total++; if (iomem_ready !== 1'b1) begin bad++; $display("FAIL rt_ready got=%b exp=1", iomem_ready); end
    total++; if (iomem_rdata !== 32'h5A5A_0002) begin bad++; $display("FAIL rt_rdata got=%h exp=5a5a0002", iomem_rdata); end
    p_ready = 4'b0000;
    step();
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL rt_buserr got=%b exp=0", bus_err); end
    cpu_op(32'h0F00_0000, 32'h0, 4'h0, rd);
    total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL rt_status got=%h exp=00000000", rd); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    int pulses;
    pulses  = 0;
    p_ready = 4'b0000;
    drive(32'h0400_0000, 32'h0, 4'h0);
    step();
    step();
    total++; if (p_sel !== 4'b0010) begin bad++; $display("FAIL rm_sel got=%b exp=0010", p_sel); end
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    #1;
    total++; if (p_sel !== 4'b0000) begin bad++; $display("FAIL rm_sel_async got=%b exp=0000", p_sel); end
    for (int i = 0; i < 2; i++) begin
      step();
      if (iomem_ready === 1'b1) pulses++;
    end
    resetn  = 1'b1;
    p_ready = 4'b0001;
    p_rdata = {96'h0, 32'h0000_0077};
    drive(32'h0300_0000, 32'h0, 4'h0);
    step();
    if (iomem_ready === 1'b1) pulses++;
    total++; if (pulses != 0) begin bad++; $display("FAIL rm_no_pulse got=%0d exp=0", pulses); end
    total++; if (p_sel !== 4'b0001) begin bad++; $display("FAIL rm_first_accept got=%b exp=0001", p_sel); end
    step();
    total++; if (iomem_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", iomem_ready); end
    total++; if (iomem_rdata !== 32'h0000_0077) begin bad++; $display("FAIL rm_rdata got=%h exp=00000077", iomem_rdata); end
    iomem_valid = 1'b0;
    p_ready     = 4'b0000;
    step();
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL rm_buserr got=%b exp=0", bus_err); end
    cpu_op(32'h0F00_0000, 32'h0, 4'h0, rd);
    total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL rm_status got=%h exp=00000000", rd); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_write();
    test_timeout();
    test_unmapped();
    test_saturate();
    test_ready_vs_timeout();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iomem_ctrl.md
IOMEM_CTRL -- requirements
Module: iomem_ctrl

Interface
REQ-001 SHALL have parameter SLOT0_PAGE, default 8'h03, addr[31:24] page of slot 0 (gpio).
REQ-002 SHALL have parameter SLOT1_PAGE, default 8'h04, page of slot 1 (audio).
REQ-003 SHALL have parameter SLOT2_PAGE, default 8'h05, page of slot 2 (oled).
REQ-004 SHALL have parameter SLOT3_PAGE, default 8'h07, page of slot 3 (i2c).
REQ-005 SHALL have parameter STAT_PAGE, default 8'h0F, page of the internal status register.
REQ-006 SHALL have parameter TIMEOUT, default 255, maximum ACCESS cycles before abort, range 1..255.
REQ-007 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-008 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port iomem_valid  input  1  CPU request valid.
REQ-010 SHALL have port iomem_ready  output  1  one-cycle CPU completion pulse.
REQ-011 SHALL have port iomem_wstrb  input  4  byte write strobes; all zero means read.
REQ-012 SHALL have port iomem_addr  input  32  request address.
REQ-013 SHALL have port iomem_wdata  input  32  write data.
REQ-014 SHALL have port iomem_rdata  output  32  read data, valid while iomem_ready=1.
REQ-015 SHALL have port p_sel  output  4  one-hot peripheral select, bit n = slot n.
REQ-016 SHALL have port p_wstrb, p_addr, p_wdata  output  4/32/32  registered copies of the request.
REQ-017 SHALL have port p_ready  input  4  per-slot completion, bit n = slot n.
REQ-018 SHALL have port p_rdata  input  128  slot n read data on bits [32n+31:32n].
REQ-019 SHALL have port bus_err  output  1  sticky; set on any timeout or unmapped access.

Function
REQ-020 SHALL implement states IDLE, ACCESS, DONE.
REQ-021 IDLE with iomem_valid=1 SHALL latch addr/wdata/wstrb into p_addr/p_wdata/p_wstrb and decode addr[31:24].
REQ-022 Mapped slot page SHALL set p_sel one-hot next cycle, clear the timeout counter, and enter ACCESS.
REQ-023 In ACCESS with p_ready[slot]=1 SHALL capture p_rdata[slot] into iomem_rdata, clear p_sel, and enter DONE; p_ready bits of unselected slots are ignored.
REQ-024 Zero-wait peripheral: valid sampled at cycle 0 -> p_sel at cycle 1 -> iomem_ready at cycle 2.
REQ-025 In ACCESS the counter SHALL increment each cycle without p_ready; on reaching TIMEOUT: iomem_rdata=32'hFFFF_FFFF, p_sel=0, error recorded, enter DONE.
REQ-026 If p_ready and the timeout both occur in the same cycle, p_ready SHALL win: no error, normal data.
REQ-027 Unmapped page SHALL go directly IDLE->DONE with rdata 32'hFFFF_FFFF and record an error; p_sel stays 0.
REQ-028 STAT_PAGE read SHALL go IDLE->DONE with rdata {err_addr[23:0], err_cnt[7:0]}.
REQ-029 STAT_PAGE write with any wstrb bit SHALL clear err_cnt, err_addr, and bus_err.
REQ-030 An error record SHALL increment err_cnt, saturating at 8'hFF, latch addr[23:0] into err_addr, and set bus_err.
REQ-031 DONE SHALL assert iomem_ready for exactly one cycle, then return to IDLE.
REQ-032 iomem_valid SHALL NOT be sampled in DONE, so one request produces one transaction.
REQ-033 iomem_rdata SHALL hold its value outside DONE.
REQ-034 At most one p_sel bit SHALL ever be set; p_sel SHALL be 0 outside ACCESS.
REQ-035 A CPU deasserting iomem_valid during ACCESS SHALL NOT abort the transaction; it completes or times out normally.

Reset
REQ-036 resetn=0 SHALL immediately force state=IDLE, iomem_ready=0, p_sel=0, iomem_rdata=0, p_addr/p_wdata/p_wstrb=0, counter=0, err_cnt=0, err_addr=0, bus_err=0.
REQ-037 Reset during ACCESS SHALL abandon the transaction with no iomem_ready pulse and no error record.
REQ-038 After reset release, the first valid request SHALL be accepted on the first rising edge with resetn=1.

Verification
REQ-039 Read addr 32'h0300_0004, p_ready[0]=1 with data 32'h0000_00A5 -> p_sel=4'b0001 at cycle 1, iomem_ready with rdata 32'h0000_00A5 at cycle 2.
REQ-040 Write addr 32'h0700_0000, wdata 32'h1234_5678, wstrb 4'hF, p_ready[3] delayed 5 cycles -> p_sel=4'b1000 held 6 cycles, p_wdata=32'h1234_5678, single iomem_ready pulse.
REQ-041 Read addr 32'h0400_0000 with p_ready held 0, TIMEOUT=8 -> abort after 8 ACCESS cycles, rdata 32'hFFFF_FFFF, bus_err=1, status read returns 32'h0000_0001.
REQ-042 Access addr 32'h0900_0010 -> iomem_ready at cycle 1, p_sel never set, status read returns 32'h0000_1001; status write wstrb 4'h1 -> status reads 0, bus_err=0.
REQ-043 300 unmapped accesses -> err_cnt saturates at 8'hFF; p_ready and timeout in the same cycle -> data returned, err_cnt unchanged.
REQ-044 resetn pulsed low mid-ACCESS -> p_sel=0 immediately, no iomem_ready pulse; the next request completes normally.
